// File: rtl/layer_pkg.sv
// Shared definitions for the layer object generator.
//   - tile codes and rotation encodings returned by a lookup
//   - object-fetch FSM state type
//   - object-RAM word offsets (three words per paddle, then ball x/y)
package layer_pkg;

    localparam logic [5:0] TILE_PADDLE_END    = 6'd1;
    localparam logic [5:0] TILE_PADDLE_BOTTOM = 6'd2;
    localparam logic [5:0] TILE_PADDLE_BODY   = 6'd3;
    localparam logic [5:0] TILE_BALL          = 6'd4;
    localparam logic [5:0] TILE_EMPTY_CODE    = 6'h3F;

    localparam logic [1:0] ROT_0   = 2'b00;
    localparam logic [1:0] ROT_90  = 2'b01;
    localparam logic [1:0] ROT_180 = 2'b10;
    localparam logic [1:0] ROT_270 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } obj_state_t;

    localparam int WORDS_PER_PLAYER = 3;
    localparam int OFS_X            = 0;
    localparam int OFS_Y            = 1;
    localparam int OFS_H            = 2;
    localparam int BALL_OFS_X       = 0;
    localparam int BALL_OFS_Y       = 1;

    function automatic int nreg(input int n_players);
        return WORDS_PER_PLAYER * n_players + 2;
    endfunction

endpackage

// File: rtl/paddle_hit.sv
// Stage-1 hit test for one paddle.
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   req_col, req_row      lookup tile coordinate
//   pad_x, pad_y, pad_h   active paddle position and height
//   hit, tile, rotate     registered result (tile/rotate meaningful only when hit)
module paddle_hit
    import layer_pkg::*;
#(
    parameter int GRID_W = 120,
    parameter int GRID_H = 68,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 7
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [COL_W-1:0] req_col,
    input  logic [ROW_W-1:0] req_row,
    input  logic [7:0]       pad_x,
    input  logic [7:0]       pad_y,
    input  logic [7:0]       pad_h,
    output logic             hit,
    output logic [5:0]       tile,
    output logic [1:0]       rotate
);

    // 10 bits holds x+1 and y+h-1 for any byte-sized position without wrapping.
    logic [9:0] col, row, x0, x1, y_top, y_bot;
    logic       in_grid, on_col0, on_col1, in_rows;

    always_comb begin
        col     = 10'(req_col);
        row     = 10'(req_row);
        x0      = 10'(pad_x);
        x1      = x0 + 10'd1;
        y_top   = 10'(pad_y);
        y_bot   = y_top + 10'(pad_h) - 10'd1;
        in_grid = (col < 10'(GRID_W)) && (row < 10'(GRID_H));
        on_col0 = (col == x0);
        on_col1 = (col == x1);
        // pad_h==0 makes y_bot meaningless, so it gates the row range.
        in_rows = (pad_h != 8'd0) && (row >= y_top) && (row <= y_bot);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hit    <= 1'b0;
            tile   <= 6'd0;
            rotate <= ROT_0;
        end else begin
            hit <= in_grid && in_rows && (on_col0 || on_col1);
            // Top row wins over bottom row so a height-1 paddle shows end caps.
            if (row == y_top) begin
                tile   <= TILE_PADDLE_END;
                rotate <= on_col0 ? ROT_0 : ROT_90;
            end else if (row == y_bot) begin
                tile   <= TILE_PADDLE_BOTTOM;
                rotate <= on_col0 ? ROT_270 : ROT_180;
            end else begin
                tile   <= TILE_PADDLE_BODY;
                rotate <= on_col0 ? ROT_0 : ROT_90;
            end
        end
    end

endmodule

// File: rtl/layer_object_generator.sv
// Object layer tile generator.
// Once per frame the object positions are fetched from the object RAM into
// shadow registers and committed atomically to the active set; tile lookups
// run through a 2-stage pipeline against the active set.
// Ports:
//   i_clk, i_rst                         clock, async active-high reset
//   i_x, i_y                             pixel position (frame-start detection)
//   i_tile_valid, i_tile_col, i_tile_row lookup request
//   o_ram_rd_en, o_ram_address           object-RAM read port
//   i_ram_data                           read data, RAM_LAT cycles after the strobe
//   o_valid, o_tile, o_rotate            lookup result, 2 cycles after request
//   o_busy                               object fetch in progress
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | waiting for frame start
// ST_FETCH  | issuing reads for words 0..NREG-1
// ST_DRAIN  | waiting RAM_LAT cycles for the last read data
// ST_COMMIT | copying shadow registers to the active set
module layer_object_generator
    import layer_pkg::*;
#(
    parameter int          N_PLAYERS  = 2,
    parameter int          GRID_W     = 120,
    parameter int          GRID_H     = 68,
    parameter int          RAM_LAT    = 1,
    parameter logic [5:0]  TILE_EMPTY = TILE_EMPTY_CODE,
    localparam int         COL_W      = $clog2(GRID_W),
    localparam int         ROW_W      = $clog2(GRID_H)
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [8:0]       i_x,
    input  logic [8:0]       i_y,
    input  logic             i_tile_valid,
    input  logic [COL_W-1:0] i_tile_col,
    input  logic [ROW_W-1:0] i_tile_row,
    output logic             o_ram_rd_en,
    output logic [5:0]       o_ram_address,
    input  logic [7:0]       i_ram_data,
    output logic             o_valid,
    output logic [5:0]       o_tile,
    output logic [1:0]       o_rotate,
    output logic             o_busy
);

    localparam int         NREG       = nreg(N_PLAYERS);
    localparam int         BALL_BASE  = WORDS_PER_PLAYER * N_PLAYERS;
    localparam logic [5:0] LAST_ADDR  = 6'(NREG - 1);
    localparam logic [1:0] DRAIN_LOAD = 2'(RAM_LAT - 1);

    function automatic logic [7:0] reset_word(input int idx);
        int k;
        int ofs;
        k   = idx / WORDS_PER_PLAYER;
        ofs = idx % WORDS_PER_PLAYER;
        if (idx == BALL_BASE + BALL_OFS_X) return 8'(GRID_W / 2);
        if (idx == BALL_BASE + BALL_OFS_Y) return 8'(GRID_H / 2);
        if (ofs == OFS_X) return (k == 0) ? 8'd1 : 8'(GRID_W - 2 - k);
        return 8'd10;
    endfunction

    obj_state_t       state_q;
    logic [1:0]       drain_cnt_q;
    logic [8:0]       x_q, y_q;
    logic             origin_prev_q;
    logic             at_origin, frame_start;
    logic [RAM_LAT-1:0] rd_pipe_v_q;
    logic [5:0]       rd_pipe_a_q [RAM_LAT];
    logic [7:0]       shadow_q [NREG];
    logic [7:0]       active_q [NREG];

    // ---------------- frame start ----------------
    assign at_origin   = (x_q == 9'd0) && (y_q == 9'd0);
    assign frame_start = at_origin && !origin_prev_q;

    // origin_prev_q resets high so a pixel counter parked at (0,0) does not
    // trigger a fetch straight out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_q           <= 9'd0;
            y_q           <= 9'd0;
            origin_prev_q <= 1'b1;
        end else begin
            x_q           <= i_x;
            y_q           <= i_y;
            origin_prev_q <= at_origin;
        end
    end

    // ---------------- fetch FSM ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            drain_cnt_q   <= 2'd0;
            o_ram_rd_en   <= 1'b0;
            o_ram_address <= 6'd0;
            o_busy        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q       <= ST_FETCH;
                        o_ram_rd_en   <= 1'b1;
                        o_ram_address <= 6'd0;
                        o_busy        <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (o_ram_address == LAST_ADDR) begin
                        state_q       <= ST_DRAIN;
                        o_ram_rd_en   <= 1'b0;
                        o_ram_address <= 6'd0;
                        drain_cnt_q   <= DRAIN_LOAD;
                    end else begin
                        o_ram_address <= o_ram_address + 6'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == 2'd0) state_q <= ST_COMMIT;
                    else                     drain_cnt_q <= drain_cnt_q - 2'd1;
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ---------------- read-address pipeline ----------------
    // Tracks which word each returning byte belongs to; cleared on reset so
    // reads issued before a reset never land in the shadow registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_pipe_v_q <= '0;
            for (int i = 0; i < RAM_LAT; i++) rd_pipe_a_q[i] <= 6'd0;
        end else begin
            rd_pipe_v_q[0] <= o_ram_rd_en;
            rd_pipe_a_q[0] <= o_ram_address;
            for (int i = 1; i < RAM_LAT; i++) begin
                rd_pipe_v_q[i] <= rd_pipe_v_q[i-1];
                rd_pipe_a_q[i] <= rd_pipe_a_q[i-1];
            end
        end
    end

    // ---------------- shadow / active registers ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) shadow_q[i] <= reset_word(i);
        end else begin
            for (int i = 0; i < NREG; i++)
                if (rd_pipe_v_q[RAM_LAT-1] && (rd_pipe_a_q[RAM_LAT-1] == 6'(i)))
                    shadow_q[i] <= i_ram_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) active_q[i] <= reset_word(i);
        end else if (state_q == ST_COMMIT) begin
            for (int i = 0; i < NREG; i++) active_q[i] <= shadow_q[i];
        end
    end

    // ---------------- lookup stage 1 ----------------
    logic [N_PLAYERS-1:0] pad_hit;
    logic [5:0]           pad_tile [N_PLAYERS];
    logic [1:0]           pad_rot  [N_PLAYERS];
    logic                 v1_q, ball_hit_q;
    logic                 req_in_grid;

    for (genvar k = 0; k < N_PLAYERS; k++) begin : g_pad
        paddle_hit #(
            .GRID_W (GRID_W),
            .GRID_H (GRID_H),
            .COL_W  (COL_W),
            .ROW_W  (ROW_W)
        ) u_paddle_hit (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .req_col (i_tile_col),
            .req_row (i_tile_row),
            .pad_x   (active_q[WORDS_PER_PLAYER*k + OFS_X]),
            .pad_y   (active_q[WORDS_PER_PLAYER*k + OFS_Y]),
            .pad_h   (active_q[WORDS_PER_PLAYER*k + OFS_H]),
            .hit     (pad_hit[k]),
            .tile    (pad_tile[k]),
            .rotate  (pad_rot[k])
        );
    end

    assign req_in_grid = (10'(i_tile_col) < 10'(GRID_W)) && (10'(i_tile_row) < 10'(GRID_H));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1_q       <= 1'b0;
            ball_hit_q <= 1'b0;
        end else begin
            v1_q       <= i_tile_valid;
            ball_hit_q <= req_in_grid
                       && (10'(i_tile_col) == 10'(active_q[BALL_BASE + BALL_OFS_X]))
                       && (10'(i_tile_row) == 10'(active_q[BALL_BASE + BALL_OFS_Y]));
        end
    end

    // ---------------- lookup stage 2: priority encode ----------------
    logic [5:0] tile_d;
    logic [1:0] rot_d;

    always_comb begin
        tile_d = TILE_EMPTY;
        rot_d  = ROT_0;
        // Walk from the lowest-priority paddle up so player 0 overrides.
        for (int k = N_PLAYERS - 1; k >= 0; k--) begin
            if (pad_hit[k]) begin
                tile_d = pad_tile[k];
                rot_d  = pad_rot[k];
            end
        end
        if (ball_hit_q) begin
            tile_d = TILE_BALL;
            rot_d  = ROT_0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_tile   <= TILE_EMPTY;
            o_rotate <= ROT_0;
        end else begin
            o_valid  <= v1_q;
            o_tile   <= v1_q ? tile_d : TILE_EMPTY;
            o_rotate <= v1_q ? rot_d  : ROT_0;
        end
    end

endmodule

// File: doc/layer_object_generator.md
LAYER_OBJECT_GENERATOR -- requirements
Module: layer_object_generator

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, number of paddles (1..4).
REQ-002 SHALL have parameter GRID_W, default 120, tile columns; COL_W = clog2(GRID_W).
REQ-003 SHALL have parameter GRID_H, default 68, tile rows; ROW_W = clog2(GRID_H).
REQ-004 SHALL have parameter RAM_LAT, default 1, object-RAM read latency in cycles (1..3).
REQ-005 SHALL have parameter TILE_EMPTY, default 6'h3F, tile code for no object.
REQ-006 i_clk  in  1  single clock; all state on rising edge.
REQ-007 i_rst  in  1  reset, asynchronous, active-high.
REQ-008 i_x  in  9  pixel column; i_y  in  9  pixel row (frame-start detection only).
REQ-009 i_tile_valid  in  1  lookup request; i_tile_col  in  COL_W; i_tile_row  in  ROW_W.
REQ-010 o_ram_rd_en  out  1  read strobe; o_ram_address  out  6  object-RAM word address.
REQ-011 i_ram_data  in  8  read data, valid RAM_LAT cycles after o_ram_rd_en.
REQ-012 o_valid  out  1; o_tile  out  6  tile code; o_rotate  out  2  rotation (00/01/10/11 = 0/90/180/270).
REQ-013 o_busy  out  1  high while object fetch in progress.

Function
REQ-014 RAM map: player k at words 3k (x), 3k+1 (y), 3k+2 (h); ball x at 3N_PLAYERS, ball y at 3N_PLAYERS+1; NREG = 3N_PLAYERS+2.
REQ-015 Frame start = registered (i_x,i_y)==(0,0) while previous registered value != (0,0); one-cycle event.
REQ-016 FSM states IDLE, FETCH, DRAIN, COMMIT; IDLE->FETCH on frame start.
REQ-017 FETCH: o_ram_rd_en=1 with addresses 0..NREG-1 on consecutive cycles, then DRAIN.
REQ-018 Each returned byte captured into shadow register indexed by a RAM_LAT-delayed address pipeline.
REQ-019 DRAIN lasts RAM_LAT cycles, then COMMIT copies all shadow registers to active registers in one cycle, then IDLE.
REQ-020 Frame start while not IDLE SHALL be ignored; o_busy=1 in FETCH/DRAIN/COMMIT.
REQ-021 Lookup latency exactly 2 cycles: o_valid(t+2)=i_tile_valid(t); stage 1 per-object compares, stage 2 priority encode; fully pipelined, one request per cycle.
REQ-022 Lookups SHALL use active registers only; a COMMIT between stages SHALL NOT mix old/new values within one request (stage-1 results are registered).
REQ-023 Paddle k covers cols x..x+1, rows y..y+h-1; compares computed at ROW_W+1/COL_W+1 width, no wrap.
REQ-024 Paddle tiles: (y,x)=1/00, (y,x+1)=1/01, (y+h-1,x)=2/11, (y+h-1,x+1)=2/10, other rows col x=3/00, col x+1=3/01.
REQ-025 h=0: paddle absent; h=1: top tiles only.
REQ-026 Ball at (ball_y,ball_x): tile 4, rotate 00.
REQ-027 Priority: ball > player 0 > player 1 > ...; no hit -> TILE_EMPTY, rotate 00.
REQ-028 o_tile/o_rotate SHALL be TILE_EMPTY/00 whenever o_valid=0.
REQ-029 Coordinates >= GRID_W/GRID_H never match.

Reset
REQ-030 On i_rst: FSM IDLE; o_valid=0, o_ram_rd_en=0, o_ram_address=0, o_busy=0, o_tile=TILE_EMPTY, o_rotate=00; pipelines cleared.
REQ-031 Active/shadow reset values: player 0 x=1, y=10, h=10; player k>0 x=GRID_W-2-k, y=10, h=10; ball x=GRID_W/2, y=GRID_H/2.
REQ-032 Reset mid-fetch SHALL abandon the fetch without committing; RAM data returning after reset release is discarded.

Structure
REQ-033 Package layer_pkg SHALL hold tile codes (PADDLE_END=1, PADDLE_BOTTOM=2, PADDLE_BODY=3, BALL=4, EMPTY), rotation constants, FSM state typedef, RAM word-offset constants.
REQ-034 Sub-module paddle_hit (one instance per player): registered hit flag, tile, rotate from active x/y/h and request col/row.

Verification
REQ-035 Reset defaults, request col=1,row=10 -> two cycles later o_valid=1, tile=1, rot=00; col=2,row=19 -> tile=2, rot=10.
REQ-036 RAM holds P0 (5,20,4), ball (5,21); (i_x,i_y) reaches (0,0) -> rd_en 8 cycles addr 0..7, COMMIT; col=5,row=21 -> tile=4 (ball priority).
REQ-037 P0 h=1 at (3,3): row 3 col 4 -> tile 1 rot 01; row 4 col 3 -> TILE_EMPTY.
REQ-038 Back-to-back requests every cycle across COMMIT -> each result matches exactly old or new object set, none missing, o_valid gap-free.
REQ-039 RAM_LAT=3: fetch captures correct bytes; second frame start during busy ignored (rd_en count stays 8).
REQ-040 Assert i_rst at FETCH address 3 -> outputs at reset values, active registers unchanged after release.
